// File: rtl/pipe_stage_elastic_pkg.sv
// Shared constants for the elastic pipeline stage.
//   INSTR_W        : instruction word width carried by every stage
//   NOP_INSTR_DFLT : default bubble instruction (addi x0, x0, 0)
package pipe_stage_elastic_pkg;
  localparam int                 INSTR_W        = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR_DFLT = 32'h0000_0013;
endpackage

// File: rtl/pipe_stage_elastic_slot.sv
// pipe_slot: one register stage of the elastic chain (valid, data, instr).
//   clk, reset       : clock, asynchronous active-high reset
//   load_i           : capture the upstream entry this cycle
//   flush_i          : kill the held entry (valid and instr only; data holds)
//   vld_i/data_i/instr_i : upstream entry
//   vld_o/data_o/instr_o : held entry
module pipe_slot
  import pipe_stage_elastic_pkg::*;
#(
  parameter int                 WIDTH     = 200,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DFLT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               flush_i,
  input  logic               vld_i,
  input  logic [WIDTH-1:0]   data_i,
  input  logic [INSTR_W-1:0] instr_i,
  output logic               vld_o,
  output logic [WIDTH-1:0]   data_o,
  output logic [INSTR_W-1:0] instr_o
);
  logic               vld_q;
  logic [WIDTH-1:0]   data_q;
  logic [INSTR_W-1:0] instr_q, instr_d;

  // Invalid entries still carry their payload, but the instr slot always
  // reads as a NOP so downstream decode never sees a stale opcode.
  assign instr_d = vld_i ? instr_i : NOP_INSTR;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q   <= 1'b0;
      data_q  <= '0;
      instr_q <= NOP_INSTR;
    end else if (flush_i) begin
      vld_q   <= 1'b0;
      instr_q <= NOP_INSTR;
    end else if (load_i) begin
      vld_q   <= vld_i;
      data_q  <= data_i;
      instr_q <= instr_d;
    end
  end

  assign vld_o   = vld_q;
  assign data_o  = data_q;
  assign instr_o = instr_q;
endmodule

// File: rtl/pipe_stage_elastic.sv
// pipe_stage_elastic: chain of STAGES valid/ready register stages with
// bubble collapsing, flush (priority over stall) and saturating
// retire/bubble performance counters.
//   clk, reset                    : clock, asynchronous active-high reset
//   in_valid/in_ready/in_data/in_instr     : upstream handshake + entry
//   out_valid/out_ready/out_data/out_instr : downstream handshake + entry
//   flush                         : kill every held entry
//   stall                         : freeze the whole chain
//   retire_cnt                    : valid non-NOP entries that left
//   bubble_cnt                    : cycles with no entry leaving
module pipe_stage_elastic
  import pipe_stage_elastic_pkg::*;
#(
  parameter int                 WIDTH     = 200,
  parameter int                 STAGES    = 1,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_INSTR_DFLT,
  parameter int                 CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [INSTR_W-1:0] out_instr,
  input  logic               flush,
  input  logic               stall,
  output logic [CNT_W-1:0]   retire_cnt,
  output logic [CNT_W-1:0]   bubble_cnt
);
  logic [STAGES-1:0]              vld, up_vld, acc, load;
  logic [STAGES-1:0][WIDTH-1:0]   data, up_data;
  logic [STAGES-1:0][INSTR_W-1:0] instr, up_instr;

  // A stage can take a new entry if it is empty or its own entry moves on;
  // evaluated from the output backwards so a single hole anywhere lets
  // everything behind it advance.
  always_comb begin
    acc = '0;
    acc[STAGES-1] = ~vld[STAGES-1] | (out_ready & ~stall);
    for (int i = STAGES - 2; i >= 0; i--) acc[i] = ~vld[i] | acc[i+1];
  end

  assign in_ready = acc[0] & ~stall & ~flush;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign up_vld[g]   = in_valid;
      assign up_data[g]  = in_data;
      assign up_instr[g] = in_instr;
    end else begin : g_body
      assign up_vld[g]   = vld[g-1];
      assign up_data[g]  = data[g-1];
      assign up_instr[g] = instr[g-1];
    end

    assign load[g] = acc[g] & ~stall;

    pipe_slot #(.WIDTH(WIDTH), .NOP_INSTR(NOP_INSTR)) u_slot (
      .clk     (clk),
      .reset   (reset),
      .load_i  (load[g]),
      .flush_i (flush),
      .vld_i   (up_vld[g]),
      .data_i  (up_data[g]),
      .instr_i (up_instr[g]),
      .vld_o   (vld[g]),
      .data_o  (data[g]),
      .instr_o (instr[g])
    );
  end

  assign out_valid = vld[STAGES-1];
  assign out_data  = data[STAGES-1];
  assign out_instr = instr[STAGES-1];

  // Performance counters; flush suppresses retirement of the output entry.
  logic             out_fire, ret_inc;
  logic [CNT_W-1:0] retire_q, retire_d, bubble_q, bubble_d;

  assign out_fire = out_valid & out_ready & ~stall & ~flush;
  assign ret_inc  = out_fire & (out_instr != NOP_INSTR);

  always_comb begin
    retire_d = retire_q;
    bubble_d = bubble_q;
    if (ret_inc && (retire_q != '1))   retire_d = retire_q + CNT_W'(1);
    if (!out_fire && (bubble_q != '1)) bubble_d = bubble_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retire_q <= '0;
      bubble_q <= '0;
    end else begin
      retire_q <= retire_d;
      bubble_q <= bubble_d;
    end
  end

  assign retire_cnt = retire_q;
  assign bubble_cnt = bubble_q;
endmodule

// File: tb/tb_pipe_stage_elastic.sv
module tb_pipe_stage_elastic;
  localparam int W = 16;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] ADDI = 32'h00A0_0113;

  logic clk, reset;
  logic in_valid, out_ready, flush, stall;
  logic [W-1:0] in_data;
  logic [31:0] in_instr;

  // dut A: 3 stages, 4-bit counters; dut B: 2 stages, 16-bit counters
  logic a_ir, a_ov, b_ir, b_ov;
  logic [W-1:0] a_od, b_od;
  logic [31:0] a_oi, b_oi;
  logic [3:0] a_rc, a_bc;
  logic [15:0] b_rc, b_bc;

  pipe_stage_elastic #(.WIDTH(W), .STAGES(3), .NOP_INSTR(NOP), .CNT_W(4)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_ir),
    .in_data(in_data), .in_instr(in_instr), .out_valid(a_ov), .out_ready(out_ready),
    .out_data(a_od), .out_instr(a_oi), .flush(flush), .stall(stall),
    .retire_cnt(a_rc), .bubble_cnt(a_bc));

  pipe_stage_elastic #(.WIDTH(W), .STAGES(2), .NOP_INSTR(NOP), .CNT_W(16)) dut_b (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(b_ir),
    .in_data(in_data), .in_instr(in_instr), .out_valid(b_ov), .out_ready(out_ready),
    .out_data(b_od), .out_instr(b_oi), .flush(flush), .stall(stall),
    .retire_cnt(b_rc), .bubble_cnt(b_bc));

  initial begin clk = 0; forever #5 clk = ~clk; end

  int total = 0, bad = 0;
  logic chk_en = 0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", nm, act, exp, $time);
    end
  endtask

  // Reference: occupancy slots per dut, position S-1 is the output.
  int SZ[2] = '{3, 2};
  int CMAX[2] = '{15, 65535};
  logic mv[2][4];
  logic [W-1:0] md[2][4];
  logic [31:0] mi[2][4];
  int mret[2], mbub[2];

  task automatic mreset();
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 4; j++) begin mv[k][j] = 0; md[k][j] = '0; mi[k][j] = NOP; end
      mret[k] = 0; mbub[k] = 0;
    end
  endtask

  function automatic logic m_in_ready(int k);
    logic hole = 0;
    for (int j = 0; j < SZ[k]; j++) if (!mv[k][j]) hole = 1;
    return (hole | out_ready) & ~stall & ~flush;
  endfunction

  // Everything below the highest slot that frees up this cycle shifts by one;
  // slots above it hold.
  task automatic mstep(int k);
    int s = SZ[k];
    int lim;
    logic fire;
    if (flush) begin
      for (int j = 0; j < s; j++) begin mv[k][j] = 0; mi[k][j] = NOP; end
      if (mbub[k] < CMAX[k]) mbub[k]++;
      return;
    end
    if (stall) begin
      if (mbub[k] < CMAX[k]) mbub[k]++;
      return;
    end
    fire = mv[k][s-1] & out_ready;
    if (fire) begin
      if (mi[k][s-1] != NOP && mret[k] < CMAX[k]) mret[k]++;
    end else if (mbub[k] < CMAX[k]) mbub[k]++;
    lim = -1;
    for (int j = 0; j < s; j++) if (!mv[k][j]) lim = j;
    if (fire) lim = s - 1;
    for (int j = lim; j >= 1; j--) begin
      mv[k][j] = mv[k][j-1]; md[k][j] = md[k][j-1]; mi[k][j] = mi[k][j-1];
    end
    if (lim >= 0) begin
      mv[k][0] = in_valid; md[k][0] = in_data; mi[k][0] = in_valid ? in_instr : NOP;
    end
  endtask

  initial begin
    mreset();
    forever begin
      @(posedge clk or posedge reset);
      if (reset) mreset();
      else begin mstep(0); mstep(1); end
    end
  end

  task automatic cmp(int k, logic ir, logic ov, logic [W-1:0] od, logic [31:0] oi, int rc, int bc);
    int s = SZ[k];
    string p = (k == 0) ? "A" : "B";
    chk({p, ".in_ready"}, ir, m_in_ready(k));
    chk({p, ".out_valid"}, ov, mv[k][s-1]);
    chk({p, ".out_instr"}, oi, mi[k][s-1]);
    if (mv[k][s-1]) chk({p, ".out_data"}, od, md[k][s-1]);
    chk({p, ".retire_cnt"}, rc, mret[k]);
    chk({p, ".bubble_cnt"}, bc, mbub[k]);
  endtask

  initial forever begin
    @(negedge clk);
    if (chk_en && !reset) begin
      cmp(0, a_ir, a_ov, a_od, a_oi, int'(a_rc), int'(a_bc));
      cmp(1, b_ir, b_ov, b_od, b_oi, int'(b_rc), int'(b_bc));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic rnd_drive();
    int r = $urandom_range(0, 2);
    in_valid  = ($urandom_range(0, 3) != 0);
    in_data   = W'($urandom);
    in_instr  = (r == 0) ? NOP : (r == 1) ? ADDI : $urandom;
    out_ready = ($urandom_range(0, 2) != 0);
    stall     = ($urandom_range(0, 15) == 0);
    flush     = ($urandom_range(0, 31) == 0);
  endtask

  logic [31:0] seq[3] = '{32'h00A0_0113, 32'h00B0_0113, 32'h00C0_0113};
  int pr, pb;

  initial begin
    reset = 0; in_valid = 0; out_ready = 0; flush = 0; stall = 0;
    in_data = '0; in_instr = NOP;
    #1 reset = 1;
    #2;
    chk("rst A.out_valid", a_ov, 0);
    chk("rst A.out_instr", a_oi, NOP);
    chk("rst B.out_instr", b_oi, NOP);
    chk("rst A.retire", a_rc, 0);
    chk("rst B.bubble", b_bc, 0);
    #9 reset = 0;
    chk_en = 1;
    tick();

    // first-entry latency through the 2-stage instance
    in_valid = 1; in_instr = 32'h0050_0093; in_data = 16'h1234; out_ready = 1;
    tick();
    in_valid = 0;
    tick();
    chk("lat B.out_valid", b_ov, 1);
    chk("lat B.out_instr", b_oi, 32'h0050_0093);
    chk("lat A.out_valid(3 stg)", a_ov, 0);
    tick();
    chk("lat B.retire", b_rc, 1);
    repeat (3) tick();

    // fill the 3-stage instance while blocked, then drain in order
    out_ready = 0; in_valid = 1;
    for (int n = 0; n < 3; n++) begin
      in_instr = seq[n]; in_data = W'(n + 16'h50);
      chk("fill A.in_ready", a_ir, 1);
      tick();
    end
    chk("full A.in_ready", a_ir, 0);
    in_valid = 0; out_ready = 1;
    for (int n = 0; n < 3; n++) begin
      chk("drain A.out_instr", a_oi, seq[n]);
      chk("drain A.out_valid", a_ov, 1);
      tick();
    end
    chk("empty A.out_valid", a_ov, 0);

    // flush and stall together on full chains
    out_ready = 0; in_valid = 1; in_instr = ADDI;
    repeat (3) tick();
    chk("full2 A.in_ready", a_ir, 0);
    pr = mret[1]; pb = mbub[1];
    flush = 1; stall = 1;
    chk("flush A.in_ready", a_ir, 0);
    chk("flush B.in_ready", b_ir, 0);
    tick();
    flush = 0; stall = 0; in_valid = 0;
    chk("flush A.out_valid", a_ov, 0);
    chk("flush A.out_instr", a_oi, NOP);
    chk("flush B.retire", b_rc, 16'(pr));
    chk("flush B.bubble", b_bc, 16'(pb + 1));

    // NOPs interleaved with real instructions: only the latter retire
    pr = mret[1]; out_ready = 1; in_valid = 1;
    for (int n = 0; n < 4; n++) begin
      in_instr = (n % 2 == 0) ? NOP : ADDI;
      tick();
    end
    in_valid = 0;
    repeat (3) tick();
    chk("nop B.retire", b_rc, 16'(pr + 2));

    // bubble counter saturation on the 4-bit instance
    out_ready = 0;
    repeat (20) tick();
    chk("sat A.bubble", a_bc, 15);

    repeat (3000) begin rnd_drive(); tick(); end

    // asynchronous reset in the middle of traffic
    rnd_drive(); flush = 0; stall = 0;
    @(posedge clk); #2;
    reset = 1;
    #1;
    chk("arst A.out_valid", a_ov, 0);
    chk("arst A.out_instr", a_oi, NOP);
    chk("arst A.retire", a_rc, 0);
    chk("arst B.out_valid", b_ov, 0);
    chk("arst B.bubble", b_bc, 0);
    #1 reset = 0;
    @(posedge clk); #1;
    repeat (200) begin rnd_drive(); tick(); end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
